// File: rtl/regfile_pkg.sv
// Shared definitions for the byte-writable register file with write bypass
// and background clear sweep.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int REGFILE_DATA_W   = 32;
    localparam int REGFILE_ADDR_W   = 5;
    localparam int REGFILE_NUM_RD   = 2;
    localparam int REGFILE_ZERO_REG = 1;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep controller: walks clear_ptr over every entry once per clear
// request or reset, reporting busy for the whole sweep.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output state_t            state,
    output logic [ADDR_W-1:0] clear_ptr,
    output logic              busy
);

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset always (re)starts a sweep from entry 0, even mid-sweep.
            state     <= CLEAR;
            clear_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state     <= CLEAR;
                        clear_ptr <= '0;
                    end
                end
                CLEAR: begin
                    clear_ptr <= clear_ptr + 1'b1;
                    if (clear_ptr == '1) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= CLEAR;
                    clear_ptr <= '0;
                end
            endcase
        end
    end

    assign busy = (state == CLEAR);

endmodule

// File: rtl/regfile_bypass.sv
// Register file with byte-enable writes, combinational reads with same-cycle
// write bypass, an optional hardwired zero entry and a sweep-based clear.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REGFILE_DATA_W,
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int NUM_RD   = REGFILE_NUM_RD,
    parameter int ZERO_REG = REGFILE_ZERO_REG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            fsm_state;
    logic [ADDR_W-1:0] clear_ptr;
    logic              clearing;
    logic              wr_fire;

    regfile_clear_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .state    (fsm_state),
        .clear_ptr(clear_ptr),
        .busy     (busy)
    );

    assign clearing = (fsm_state == CLEAR);

    // A write only lands in IDLE, outside reset, and never on the zero entry.
    assign wr_fire = wr_en && !busy && !rst &&
                     !((ZERO_REG != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing) begin
                mem[clear_ptr] <= '0;
            end else if (wr_fire) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (wr_be[b]) begin
                        mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] word;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            word = mem[addr];
            if (wr_fire && (addr == wr_addr)) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (wr_be[b]) begin
                        word[8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
            // Zero entry and in-progress sweep override any stored or bypassed data.
            if (busy || ((ZERO_REG != 0) && (addr == '0))) begin
                word = '0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = word;
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed self-checking bench for regfile_bypass (32-bit, 32 entries,
// two read ports, zero register enabled).
module tb_regfile_bypass;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     clk;
    logic                     rst;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [DATA_W/8-1:0]      wr_be;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     clr_req;
    logic                     busy;

    int n_checks;
    int n_errors;
    int nb;

    regfile_bypass #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_be  (wr_be),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .clr_req(clr_req),
        .busy   (busy)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [DATA_W/8-1:0] be);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] exp);
        @(negedge clk);
        rd_addr = {a, a};
        #1;
        check(tag, rd_data, {exp, exp});
    endtask

    // Counts consecutive busy cycles starting at the current negedge.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_be    = '0;
        rd_addr  = '0;
        clr_req  = 1'b0;

        // Reset sweep: one-cycle rst pulse gives exactly 32 busy cycles.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", {63'd0, busy}, 64'd1);
        count_busy(nb);
        check("reset_busy_len", 64'(nb), 64'd32);
        check("idle_after_reset", {63'd0, busy}, 64'd0);
        for (int a = 1; a < 32; a++) begin
            read_check($sformatf("reset_zero_%0d", a), ADDR_W'(a), 32'h0);
        end

        // Byte enables.
        do_write(5'd3, 32'hAABBCCDD, 4'b1111);
        read_check("be_full", 5'd3, 32'hAABBCCDD);
        do_write(5'd3, 32'h11223344, 4'b0101);
        read_check("be_partial", 5'd3, 32'hAA22CC44);

        // Same-cycle bypass, partial bytes; other port reads stored entry 3.
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hDEADBEEF;
        wr_be   = 4'b0011;
        rd_addr = {5'd3, 5'd5};
        #1;
        check("bypass_p0", {32'd0, rd_data[31:0]}, 64'h0000_0000_0000_BEEF);
        check("bypass_p1", {32'd0, rd_data[63:32]}, 64'h0000_0000_AA22_CC44);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        read_check("bypass_stored", 5'd5, 32'h0000BEEF);

        // Independent ports: same address and distinct addresses.
        do_write(5'd10, 32'h0BADCAFE, 4'b1111);
        read_check("same_addr", 5'd10, 32'h0BADCAFE);
        @(negedge clk);
        rd_addr = {5'd3, 5'd10};
        #1;
        check("diff_addr", rd_data, {32'hAA22CC44, 32'h0BADCAFE});

        // Zero register, including the write cycle itself.
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'hFFFFFFFF;
        wr_be   = 4'b1111;
        rd_addr = {5'd0, 5'd0};
        #1;
        check("zero_wr_cycle", rd_data, 64'd0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        read_check("zero_after", 5'd0, 32'h0);

        // Write coinciding with clr_req, then a write and a clr_req during the sweep.
        @(negedge clk);
        clr_req = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'h12345678;
        wr_be   = 4'b1111;
        @(negedge clk);
        clr_req = 1'b0;
        wr_en   = 1'b0;
        rd_addr = {5'd7, 5'd3};
        #1;
        check("clr_busy", {63'd0, busy}, 64'd1);
        check("clr_read_zero", rd_data, 64'd0);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 5'd1;
        wr_data = 32'hCAFEF00D;
        wr_be   = 4'b1111;
        rd_addr = {5'd1, 5'd1};
        #1;
        check("sweep_no_bypass", rd_data, 64'd0);
        @(negedge clk);
        wr_en = 1'b0;
        count_busy(nb);
        check("clr_busy_len", 64'(nb), 64'd29);
        read_check("clr_entry7", 5'd7, 32'h0);
        read_check("clr_entry1", 5'd1, 32'h0);
        read_check("clr_entry3", 5'd3, 32'h0);
        read_check("clr_entry10", 5'd10, 32'h0);

        // Reset at sweep cycle 10 restarts the full sweep.
        do_write(5'd4, 32'h00000055, 4'b1111);
        read_check("pre_rst_write", 5'd4, 32'h00000055);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_sweep_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(nb);
        check("rst_mid_len", 64'(nb), 64'd32);
        read_check("rst_mid_entry4", 5'd4, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
